// File: rtl/pmem_burst_adaptor_pkg.sv
// Shared types and helpers for the line-to-burst memory adaptor.
// A 256-bit cache line moves as four 64-bit beats on the burst side.
package pmem_burst_pkg;

  localparam int unsigned BEAT_WIDTH_DEF = 64;
  localparam int unsigned BEATS_DEF      = 4;
  localparam int unsigned LINE_WIDTH     = BEAT_WIDTH_DEF * BEATS_DEF;
  localparam int unsigned CNT_WIDTH      = $clog2(BEATS_DEF);
  localparam int unsigned ADDR_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } burst_state_t;

  // Lines are 32 bytes, so the low five address bits carry no information.
  function automatic logic [ADDR_WIDTH-1:0] align_line(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:5], 5'b0_0000};
  endfunction

endpackage

// File: rtl/pmem_burst_adaptor_beat_counter.sv
// Beat index for the current burst, shared by the read and write paths.
// Clear has priority over increment so the last beat returns it to zero.
module burst_beat_counter
  import pmem_burst_pkg::*;
#(
  parameter int unsigned BEATS = BEATS_DEF,
  parameter int unsigned CW    = CNT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          is_last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_last_o = (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/pmem_burst_adaptor.sv
// Splits a cache-line read or write into a fixed burst of BEATS memory beats
// and reassembles read beats into a line with a single-cycle completion pulse.
module pmem_burst_adaptor
  import pmem_burst_pkg::*;
#(
  parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF,
  parameter int unsigned BEATS      = BEATS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       line_address,
  input  logic                        line_read,
  input  logic                        line_write,
  input  logic [BEAT_WIDTH*BEATS-1:0] line_wdata,
  output logic [BEAT_WIDTH*BEATS-1:0] line_rdata,
  output logic                        line_resp,
  output logic [ADDR_WIDTH-1:0]       burst_address,
  output logic                        burst_read,
  output logic                        burst_write,
  output logic [BEAT_WIDTH-1:0]       burst_wdata,
  input  logic [BEAT_WIDTH-1:0]       burst_rdata,
  input  logic                        burst_resp
);

  localparam int unsigned LW = BEAT_WIDTH * BEATS;
  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  burst_state_t    state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]   wline_q, wline_d;
  logic [LW-1:0]   rline_q, rline_d;

  logic [CW-1:0]   cnt;
  logic            cnt_is_last;
  logic            beat_ack;
  logic            cnt_clr;

  // Beats only count while a burst is actually in flight.
  assign beat_ack = burst_resp && ((state_q == RD) || (state_q == WR));
  assign cnt_clr  = beat_ack && cnt_is_last;

  burst_beat_counter #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .inc_i     (beat_ack),
    .cnt_o     (cnt),
    .is_last_o (cnt_is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (line_read) begin
          state_d = RD;
        end else if (line_write) begin
          state_d = WR;
        end
      end
      RD:      if (cnt_clr) state_d = DONE;
      WR:      if (cnt_clr) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_read  = (state_q == RD);
    burst_write = (state_q == WR);
    line_resp   = (state_q == DONE);
  end

  // Request fields are captured only on acceptance; later input changes are ignored.
  always_comb begin
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    if (state_q == IDLE) begin
      if (line_read || line_write) begin
        addr_d = align_line(line_address);
      end
      if (!line_read && line_write) begin
        wline_d = line_wdata;
      end
    end
    if ((state_q == RD) && burst_resp) begin
      for (int b = 0; b < BEATS; b++) begin
        if (cnt == CW'(b)) begin
          rline_d[b*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    burst_wdata = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt == CW'(b)) begin
        burst_wdata = wline_q[b*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  end

  assign burst_address = addr_q;
  assign line_rdata    = rline_q;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Directed bench for pmem_burst_adaptor with a small memory model and
// scoreboard queues for expected read lines and write beats.
module tb_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  line_address;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int checks   = 0;
  int failures = 0;

  logic [255:0] rd_q[$];
  logic [63:0]  wq[$];
  logic [255:0] last_rline;

  pmem_burst_adaptor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_address  (line_address),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_burst(input bit want_rd, input string tag);
    for (int i = 0; i < 10; i++) begin
      if ((want_rd ? burst_read : burst_write) === 1'b1) break;
      @(negedge clk);
    end
    chk(tag, {255'b0, (want_rd ? burst_read : burst_write)}, 256'd1);
  endtask

  task automatic start_req(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] rline, input logic [255:0] wline);
    @(negedge clk);
    line_address = addr;
    line_read    = rd;
    line_write   = wr;
    line_wdata   = wline;
    if (rd) rd_q.push_back(rline);
    if (wr) for (int b = 0; b < 4; b++) wq.push_back(wline[b*64 +: 64]);
  endtask

  task automatic run_read(input logic [255:0] mem_line, input int gap,
                          input logic [31:0] exp_addr, input bit disturb);
    logic [255:0] exp_line;
    wait_burst(1'b1, "rd_start");
    chk("rd_addr", {224'b0, burst_address}, {224'b0, exp_addr});
    if (disturb) begin
      line_address = ~line_address;
      line_wdata   = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    end
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        burst_resp = 1'b0;
        @(negedge clk);
        chk("rd_gap_hold", {254'b0, burst_read, line_resp}, 256'd2);
      end
      burst_rdata = mem_line[b*64 +: 64];
      burst_resp  = 1'b1;
      @(negedge clk);
      burst_resp  = 1'b0;
      if (b < 3) chk("rd_no_early_resp", {254'b0, burst_read, line_resp}, 256'd2);
    end
    chk("rd_resp_pulse", {254'b0, burst_read, line_resp}, 256'd1);
    chk("rd_addr_stable", {224'b0, burst_address}, {224'b0, exp_addr});
    exp_line = rd_q.pop_front();
    chk("rd_line", line_rdata, exp_line);
    last_rline = exp_line;
    line_read = 1'b0;
    @(negedge clk);
    chk("rd_resp_single", {255'b0, line_resp}, 256'd0);
  endtask

  task automatic run_write(input int gap, input logic [31:0] exp_addr, input bit disturb);
    logic [63:0] exp_beat;
    wait_burst(1'b0, "wr_start");
    chk("wr_addr", {224'b0, burst_address}, {224'b0, exp_addr});
    if (disturb) begin
      line_address = ~line_address;
      line_wdata   = {4{64'hDEAD_DEAD_DEAD_DEAD}};
    end
    for (int b = 0; b < 4; b++) begin
      exp_beat = wq.pop_front();
      for (int g = 0; g < gap; g++) begin
        burst_resp = 1'b0;
        chk("wr_gap_beat", {192'b0, burst_wdata}, {192'b0, exp_beat});
        @(negedge clk);
      end
      chk("wr_beat", {192'b0, burst_wdata}, {192'b0, exp_beat});
      burst_resp = 1'b1;
      @(negedge clk);
      burst_resp = 1'b0;
      if (b < 3) chk("wr_no_early_resp", {254'b0, burst_write, line_resp}, 256'd2);
    end
    chk("wr_resp_pulse", {254'b0, burst_write, line_resp}, 256'd1);
    line_write = 1'b0;
    @(negedge clk);
    chk("wr_resp_single", {255'b0, line_resp}, 256'd0);
  endtask

  initial begin
    logic [255:0] l1, l2, l3, l4, wl1, wl2;
    l1  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    l2  = {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    l3  = {64'hA5A5_A5A5_0000_0003, 64'hA5A5_A5A5_0000_0002,
           64'hA5A5_A5A5_0000_0001, 64'hA5A5_A5A5_0000_0000};
    l4  = {64'h0F0F_0F0F_0F0F_0F0F, 64'hCAFE_F00D_1234_5678,
           64'h1357_9BDF_2468_ACE0, 64'h0000_0000_FFFF_FFFF};
    wl1 = {64'hD, 64'hC, 64'hB, 64'hA};
    wl2 = {64'h1111_0000_0000_0004, 64'h1111_0000_0000_0003,
           64'h1111_0000_0000_0002, 64'h1111_0000_0000_0001};

    rst_n = 1'b0;
    line_address = '0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
    burst_rdata = '0; burst_resp = 1'b0;
    #1;
    chk("reset_ctl", {253'b0, burst_read, burst_write, line_resp}, 256'd0);
    chk("reset_rdata", line_rdata, 256'd0);
    chk("reset_wdata_addr", {160'b0, burst_wdata, burst_address}, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // contiguous read, unaligned address
    start_req(1'b1, 1'b0, 32'h0000_1234, l1, '0);
    run_read(l1, 0, 32'h0000_1220, 1'b0);

    // gapped write with mid-burst input disturbance
    start_req(1'b0, 1'b1, 32'h0000_2F7F, '0, wl1);
    run_write(2, 32'h0000_2F60, 1'b1);
    chk("rdata_kept_after_wr", line_rdata, last_rline);

    // gapped read with mid-burst disturbance
    start_req(1'b1, 1'b0, 32'hABCD_EF1F, l2, '0);
    run_read(l2, 1, 32'hABCD_EF00, 1'b1);

    // read and write together: read first, then the pending write
    start_req(1'b1, 1'b1, 32'h1000_0044, l3, wl2);
    run_read(l3, 0, 32'h1000_0040, 1'b0);
    run_write(0, 32'h1000_0040, 1'b0);
    chk("rdata_kept_after_wr2", line_rdata, l3);

    // reset after two read beats
    @(negedge clk);
    line_address = 32'h0000_8040; line_read = 1'b1;
    wait_burst(1'b1, "rst_rd_start");
    for (int b = 0; b < 2; b++) begin
      burst_rdata = l4[b*64 +: 64];
      burst_resp  = 1'b1;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {253'b0, burst_read, burst_write, line_resp}, 256'd0);
    chk("async_rst_rdata", line_rdata, 256'd0);
    chk("async_rst_wdata_addr", {160'b0, burst_wdata, burst_address}, 256'd0);
    line_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {255'b0, line_resp}, 256'd0);
    end
    rst_n = 1'b1;
    start_req(1'b1, 1'b0, 32'h0000_8055, l4, '0);
    run_read(l4, 0, 32'h0000_8040, 1'b0);

    // spurious beat strobes while idle must not advance the counter
    @(negedge clk);
    burst_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_spurious_quiet", {253'b0, burst_read, burst_write, line_resp}, 256'd0);
    end
    burst_resp = 1'b0;
    start_req(1'b1, 1'b0, 32'hFFFF_FFFF, l2, '0);
    run_read(l2, 0, 32'hFFFF_FFE0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_rd_empty", {224'b0, 32'(rd_q.size())}, 256'd0);
    chk("sb_wr_empty", {224'b0, 32'(wq.size())}, 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
